// File: rtl/fetch_pair_buffer.sv
// Instruction fetch queue feeding the dual-issue scheduler: credit-limited sequential
// fetch, circular word buffer, and presentation/pop of the two oldest words.
module fetch_pair_buffer #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int         CW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          n_rst,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic          imem_ready,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    input  logic          freeze1,
    input  logic          freeze2,
    input  logic          drain,
    output logic [31:0]   instruction0,
    output logic [31:0]   instruction1,
    output logic          nothing_filled,
    output logic [CW-1:0] count
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [31:0]   r_mem [DEPTH];

    logic [CW:0]   w_credit;
    logic          w_accept;
    logic          w_drop;
    logic          w_push;
    logic          w_nf;
    logic          w_consume;
    logic [1:0]    w_pop;
    logic [AW-1:0] w_head1;

    // Words leaving the buffer this cycle: a full pair when two are held, else the lone word.
    function automatic logic [1:0] pop_amount(input logic consume, input logic [CW-1:0] occ);
        if (!consume)
            return 2'd0;
        return (occ >= CW'(2)) ? 2'd2 : 2'd1;
    endfunction

    // ---- request side: outstanding responses always have a reserved slot
    assign w_credit  = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req  = !n_rst && !redirect && (w_credit < DEPTH_C);
    assign imem_addr = r_pc;
    assign w_accept  = imem_req && imem_ready;

    // ---- response side: responses to pre-redirect fetches are dropped
    assign w_drop = imem_rvalid && (r_discard != '0);
    assign w_push = !n_rst && !redirect && imem_rvalid && (r_discard == '0);

    // ---- presentation / pop
    assign w_nf      = (r_count == '0) || ((r_count == CW'(1)) && !drain);
    assign w_consume = !freeze1 && !freeze2 && !w_nf && !redirect;
    assign w_pop     = pop_amount(w_consume, r_count);
    assign w_head1   = r_head + AW'(1);

    assign nothing_filled = w_nf;
    assign instruction0   = w_nf ? 32'h0 : r_mem[r_head];
    assign instruction1   = (r_count >= CW'(2)) ? r_mem[w_head1] : 32'h0;
    assign count          = r_count;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_pc          <= RESET_PC;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (redirect) begin
            // Everything still in flight becomes garbage; a response landing now is dropped too.
            r_pc          <= redirect_pc;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_outstanding <= r_outstanding - CW'(imem_rvalid);
            r_discard     <= r_outstanding - CW'(imem_rvalid);
        end else begin
            if (w_accept)
                r_pc <= r_pc + 32'd4;
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(imem_rvalid);
            if (w_drop)
                r_discard <= r_discard - CW'(1);
            if (w_push)
                r_tail <= r_tail + AW'(1);
            r_head  <= r_head + AW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_tail] <= imem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!n_rst && imem_rvalid)
            assert (r_outstanding != '0);
        if (w_push && (w_pop == 2'd0))
            assert (r_count != CW'(DEPTH));
    end

endmodule

// File: tb/tb_fetch_pair_buffer.sv
// Bench for fetch_pair_buffer: in-order memory responder plus a queue-based model
// of the fetch stream, directed scenarios and a randomized soak.
module tb_fetch_pair_buffer;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CW       = $clog2(DEPTH) + 1;

    logic          clk;
    logic          n_rst;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ready;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          freeze1;
    logic          freeze2;
    logic          drain;
    logic [31:0]   instruction0;
    logic [31:0]   instruction1;
    logic          nothing_filled;
    logic [CW-1:0] count;

    fetch_pair_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .n_rst(n_rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .freeze1(freeze1), .freeze2(freeze2), .drain(drain),
        .instruction0(instruction0), .instruction1(instruction1),
        .nothing_filled(nothing_filled), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: fetch pc, accepted-but-unanswered requests, words to throw away, buffered words.
    logic [31:0] m_pc;
    int          m_pending;
    int          m_discard;
    logic [31:0] m_q[$];

    // Memory environment: in-order responder with random latency.
    typedef struct { logic [31:0] addr; int due; } req_t;
    req_t        e_q[$];
    int          cyc = 0;
    int          lat_max = 0;
    int          rv_pct = 100;
    logic        a_req;
    logic [31:0] a_addr;

    logic          e_nf;
    logic [31:0]   e_i0;
    logic [31:0]   e_i1;
    logic          e_req;
    logic [CW-1:0] e_count;
    logic [31:0]   e_addr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic calc_expect();
        int n;
        n       = m_q.size();
        e_nf    = (n == 0) || (n == 1 && !drain);
        e_i0    = e_nf ? 32'h0 : m_q[0];
        e_i1    = (n >= 2) ? m_q[1] : 32'h0;
        e_count = CW'(n);
        e_req   = !n_rst && !redirect && (n + m_pending < DEPTH);
        e_addr  = m_pc;
    endtask

    task automatic tick();
        int n;
        @(negedge clk);
        a_req  = imem_req;
        a_addr = imem_addr;
        calc_expect();
        n = m_q.size();
        @(posedge clk);
        if (n_rst) begin
            m_pc = RESET_PC; m_pending = 0; m_discard = 0; m_q.delete();
        end else if (redirect) begin
            m_pending = m_pending - (imem_rvalid ? 1 : 0);
            m_discard = m_pending;
            m_q.delete();
            m_pc = redirect_pc;
        end else begin
            if (!freeze1 && !freeze2 && !e_nf)
                for (int i = 0; i < ((n >= 2) ? 2 : 1); i++) void'(m_q.pop_front());
            if (imem_rvalid) begin
                m_pending--;
                if (m_discard > 0) m_discard--;
                else m_q.push_back(imem_rdata);
            end
            if (e_req && imem_ready) begin
                m_pending++;
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        if (n_rst) e_q.delete();
        else if (a_req && imem_ready) e_q.push_back('{a_addr, cyc + int'($urandom_range(lat_max, 0))});
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (e_q.size() > 0 && e_q[0].due <= cyc && int'($urandom_range(99, 0)) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(e_q[0].addr);
            void'(e_q.pop_front());
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        n_rst = 1'b1; redirect = 1'b0; freeze1 = 1'b0; freeze2 = 1'b0;
        drain = 1'b0; imem_ready = 1'b0; lat_max = 0; rv_pct = 100;
        tick();
        n_rst = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b1; redirect = 1'b0; freeze1 = 1'b0; freeze2 = 1'b0;
        drain = 1'b0; imem_ready = 1'b1; redirect_pc = 32'h0;
        tick();
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        tick();
        n_rst = 1'b0;
        #1;
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (nothing_filled !== 1'b1) begin n_fail++; $display("FAIL reset_nf got=%b exp=1", nothing_filled); end
        n_checks++; if (instruction0 !== 32'h0) begin n_fail++; $display("FAIL reset_i0 got=%h exp=0", instruction0); end
        n_checks++; if (instruction1 !== 32'h0) begin n_fail++; $display("FAIL reset_i1 got=%h exp=0", instruction1); end
        n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req_after got=%b exp=1", imem_req); end
    endtask

    task automatic test_sequential();
        do_reset();
        imem_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            calc_expect();
            n_checks++; if (imem_addr !== RESET_PC + 32'(4 * k)) begin n_fail++; $display("FAIL seq_addr k=%0d got=%h exp=%h", k, imem_addr, RESET_PC + 32'(4 * k)); end
            n_checks++; if (nothing_filled !== e_nf) begin n_fail++; $display("FAIL seq_nf k=%0d got=%b exp=%b", k, nothing_filled, e_nf); end
            n_checks++; if (instruction0 !== e_i0) begin n_fail++; $display("FAIL seq_i0 k=%0d got=%h exp=%h", k, instruction0, e_i0); end
            n_checks++; if (instruction1 !== e_i1) begin n_fail++; $display("FAIL seq_i1 k=%0d got=%h exp=%h", k, instruction1, e_i1); end
            if (k == 3) begin
                n_checks++; if (instruction0 !== word_of(RESET_PC) || instruction1 !== word_of(RESET_PC + 32'd4) || nothing_filled !== 1'b0) begin
                    n_fail++; $display("FAIL seq_first_pair got=%h/%h nf=%b exp=%h/%h nf=0", instruction0, instruction1, nothing_filled, word_of(RESET_PC), word_of(RESET_PC + 32'd4)); end
            end
            tick();
        end
    endtask

    task automatic test_full();
        do_reset();
        freeze1 = 1'b1; imem_ready = 1'b1;
        for (int k = 0; k < 40 && !(m_q.size() == DEPTH && m_pending == 0); k++) tick();
        #1;
        n_checks++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_count got=%0d exp=%0d", count, DEPTH); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req got=%b exp=0", imem_req); end
        n_checks++; if (nothing_filled !== 1'b0) begin n_fail++; $display("FAIL full_nf got=%b exp=0", nothing_filled); end
        imem_ready = 1'b0; freeze1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            #1;
            n_checks++; if (count !== CW'(DEPTH - 2 * k)) begin n_fail++; $display("FAIL drain_count k=%0d got=%0d exp=%0d", k, count, DEPTH - 2 * k); end
            n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL drain_req k=%0d got=%b exp=1", k, imem_req); end
        end
    endtask

    task automatic test_drain();
        do_reset();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        #1;
        n_checks++; if (count !== CW'(1)) begin n_fail++; $display("FAIL lone_count got=%0d exp=1", count); end
        n_checks++; if (nothing_filled !== 1'b1) begin n_fail++; $display("FAIL lone_nf got=%b exp=1", nothing_filled); end
        drain = 1'b1;
        #1;
        n_checks++; if (nothing_filled !== 1'b0) begin n_fail++; $display("FAIL drain_nf got=%b exp=0", nothing_filled); end
        n_checks++; if (instruction0 !== word_of(RESET_PC)) begin n_fail++; $display("FAIL drain_i0 got=%h exp=%h", instruction0, word_of(RESET_PC)); end
        n_checks++; if (instruction1 !== 32'h0) begin n_fail++; $display("FAIL drain_i1 got=%h exp=0", instruction1); end
        tick();
        #1;
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL drain_pop got=%0d exp=0", count); end
        drain = 1'b0;
    endtask

    task automatic test_redirect();
        bit found;
        do_reset();
        rv_pct = 0; imem_ready = 1'b1;
        ticks(3);
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req got=%b exp=0", imem_req); end
        tick();
        redirect = 1'b0; rv_pct = 100; drain = 1'b1;
        #1;
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL redir_count got=%0d exp=0", count); end
        n_checks++; if (imem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_addr got=%h exp=00000100", imem_addr); end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (nothing_filled === 1'b0) found = 1'b1;
            else begin tick(); #1; end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL redir_wait got=timeout exp=word"); end
        n_checks++; if (instruction0 !== word_of(32'h100)) begin n_fail++; $display("FAIL redir_word got=%h exp=%h", instruction0, word_of(32'h100)); end
        drain = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        freeze1 = 1'b1; imem_ready = 1'b1;
        ticks(7);
        imem_ready = 1'b0;
        ticks(3);
        freeze1 = 1'b0;
        ticks(3);
        drain = 1'b1;
        tick();
        drain = 1'b0; freeze1 = 1'b1; imem_ready = 1'b1;
        ticks(3);
        imem_ready = 1'b0;
        ticks(3);
        #1;
        n_checks++; if (count !== CW'(3)) begin n_fail++; $display("FAIL wrap_count got=%0d exp=3", count); end
        n_checks++; if (instruction0 !== word_of(32'h1C)) begin n_fail++; $display("FAIL wrap_i0 got=%h exp=%h", instruction0, word_of(32'h1C)); end
        n_checks++; if (instruction1 !== word_of(32'h20)) begin n_fail++; $display("FAIL wrap_i1 got=%h exp=%h", instruction1, word_of(32'h20)); end
        freeze1 = 1'b0;
        tick();
        #1;
        n_checks++; if (count !== CW'(1) || nothing_filled !== 1'b1) begin n_fail++; $display("FAIL wrap_pop got=%0d nf=%b exp=1 nf=1", count, nothing_filled); end
        drain = 1'b1;
        #1;
        n_checks++; if (instruction0 !== word_of(32'h24) || instruction1 !== 32'h0) begin n_fail++; $display("FAIL wrap_last got=%h/%h exp=%h/0", instruction0, instruction1, word_of(32'h24)); end
        drain = 1'b0;
    endtask

    task automatic test_push_pop2();
        do_reset();
        freeze1 = 1'b1; imem_ready = 1'b1;
        ticks(3);
        imem_ready = 1'b0; freeze1 = 1'b0;
        #1;
        n_checks++; if (count !== CW'(2) || nothing_filled !== 1'b0) begin n_fail++; $display("FAIL pp_pre got=%0d nf=%b exp=2 nf=0", count, nothing_filled); end
        tick();
        drain = 1'b1;
        #1;
        n_checks++; if (count !== CW'(1)) begin n_fail++; $display("FAIL pp_count got=%0d exp=1", count); end
        n_checks++; if (instruction0 !== word_of(32'h8)) begin n_fail++; $display("FAIL pp_word got=%h exp=%h", instruction0, word_of(32'h8)); end
        drain = 1'b0;
    endtask

    task automatic test_random();
        lat_max = 3; rv_pct = 70;
        for (int k = 0; k < 1500; k++) begin
            n_rst       = ($urandom_range(199, 0) == 0);
            imem_ready  = ($urandom_range(99, 0) < 70);
            freeze1     = ($urandom_range(99, 0) < 20);
            freeze2     = ($urandom_range(99, 0) < 20);
            drain       = ($urandom_range(99, 0) < 30);
            redirect    = ($urandom_range(99, 0) < 3);
            redirect_pc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            #1;
            calc_expect();
            n_checks++; if (count !== e_count) begin n_fail++; $display("FAIL rnd_count k=%0d got=%0d exp=%0d", k, count, e_count); end
            n_checks++; if (nothing_filled !== e_nf) begin n_fail++; $display("FAIL rnd_nf k=%0d got=%b exp=%b", k, nothing_filled, e_nf); end
            n_checks++; if (instruction0 !== e_i0) begin n_fail++; $display("FAIL rnd_i0 k=%0d got=%h exp=%h", k, instruction0, e_i0); end
            n_checks++; if (instruction1 !== e_i1) begin n_fail++; $display("FAIL rnd_i1 k=%0d got=%h exp=%h", k, instruction1, e_i1); end
            n_checks++; if (imem_req !== e_req) begin n_fail++; $display("FAIL rnd_req k=%0d got=%b exp=%b", k, imem_req, e_req); end
            n_checks++; if (imem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr k=%0d got=%h exp=%h", k, imem_addr, e_addr); end
            tick();
        end
        n_rst = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_reset_mid();
        n_rst = 1'b0; redirect = 1'b0; freeze1 = 1'b0; freeze2 = 1'b0;
        drain = 1'b0; imem_ready = 1'b1; lat_max = 1; rv_pct = 100;
        ticks(9);
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0;
        #1;
        n_checks++; if (nothing_filled !== 1'b1) begin n_fail++; $display("FAIL mid_nf got=%b exp=1", nothing_filled); end
        n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL mid_addr got=%h exp=%h", imem_addr, RESET_PC); end
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL mid_count got=%0d exp=0", count); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; freeze1 = 1'b0; freeze2 = 1'b0; drain = 1'b0;
        m_pc = RESET_PC; m_pending = 0; m_discard = 0;
        test_reset();
        test_sequential();
        test_full();
        test_drain();
        test_redirect();
        test_wrap();
        test_push_pop2();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
